data_recv_channel: RTL and testbench
====================================

// Module: data_recv_channel
// PURPOSE
//   AXI read-data receive stage of the memcopy engine; consumes the R channel for bursts issued by the address send channel.
//   Checks each beat against the expected burst length (pushed by the address stage on every AR handshake) and checks RRESP.
//   Forwards payload through a 1-deep output register; raises data_error on the first fault and data_recv_done when all beats land.
// PARAMETERS
//   DATA_WIDTH      512  R-channel / output data width in bits
//   LEN_FIFO_DEPTH  8    expected-burst-length FIFO entries (power of 2, >=2)
// PORTS
//   clk              in   1           clock
//   rst              in   1           asynchronous reset, active-high
//   engine_start     in   1           1-cycle pulse: start new transfer
//   total_beat_count in   40          beats expected for the transfer (sampled on engine_start)
//   len_push         in   1           push burst length (AR valid&ready from address stage)
//   len_in           in   8           AXI LEN of pushed burst (beats-1)
//   len_fifo_full    out  1           FIFO full; address stage must hold ARVALID low
//   axi_rdata        in   DATA_WIDTH  read data
//   axi_rresp        in   2           read response
//   axi_rlast        in   1           last beat of burst
//   axi_rvalid       in   1           read valid
//   axi_rready       out  1           read ready
//   data_out         out  DATA_WIDTH  registered payload
//   data_out_valid   out  1           payload valid
//   data_out_ready   in   1           downstream accepts payload
//   data_error       out  1           sticky fault flag (feeds address stage)
//   error_code       out  2           01 RRESP!=OKAY, 10 RLAST misplaced, 11 beat with empty len FIFO
//   data_recv_done   out  1           1-cycle pulse: all beats delivered downstream
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, FIFO empty, counters 0. rst mid-transfer aborts immediately; no done pulse.
//   FSM: IDLE -> RECV on engine_start (total_beat_count!=0); IDLE -> DONE on engine_start with count 0.
//     RECV -> DONE when received==total and output register empty (or emptying this cycle).
//     RECV -> ERROR on any fault; DONE -> IDLE after 1 cycle; ERROR -> IDLE only on engine_start (then -> RECV as above).
//   engine_start: flushes len FIFO, clears counters, clears data_error/error_code. Ignored outside IDLE/ERROR.
//   axi_rready = (RECV && (!data_out_valid || data_out_ready)) || ERROR. In ERROR beats are drained and discarded.
//   Beat accept (rvalid&rready in RECV): data_out <= rdata, data_out_valid <= 1 next cycle (latency 1);
//     data_out_valid clears on data_out_ready when no new beat accepted same cycle. Accept+drain same cycle keeps valid=1.
//   Received counter: 40-bit, +1 per accepted beat in RECV; beat_in_burst: 9-bit, compares to FIFO head.
//   Checks per accepted beat, priority 11 > 01 > 10:
//     FIFO empty -> 11. rresp!=0 -> 01. rlast != (beat_in_burst==head) -> 10.
//   Faulting beat is not forwarded; data_error=1 and error_code latched next cycle; first fault wins.
//   On beat with rlast (no fault): pop FIFO, beat_in_burst <= 0. Push and pop same cycle allowed when full.
//   len_push while full: ignored (address stage contract violation, not flagged). Pushes accepted in any state except IDLE.
//   len_fifo_full = (count == LEN_FIFO_DEPTH).
//   data_recv_done high exactly one cycle in DONE; data_error never asserted together with done.
//   Beats beyond total_beat_count are not accepted (rready low outside RECV/ERROR).
// TESTING
//   T1: start, total=8, push len=3,3; 8 OKAY beats rlast at 4,8, ready=1 -> 8 outputs in order, done 1 cycle after last output.
//   T2: total=4, push len=3, data_out_ready toggled 1/0 -> no beat lost/duplicated, rready low while out reg full & ready=0.
//   T3: beat 2 with rresp=2'b10 -> data_error=1, error_code=01, beat 2 not forwarded, rready stays 1 in ERROR, no done.
//   T4: len=3 pushed, rlast on beat 3 -> error_code=10; new engine_start clears error, next clean 4-beat transfer passes.
//   T5: rvalid with empty FIFO -> error_code=11; push 8 lens with no R -> len_fifo_full=1, 9th push ignored.
//   T6: start total=0 -> done pulse 2 cycles later; assert rst mid-burst -> all outputs 0 next cycle, FIFO empty.

Source files
------------

// File: rtl/data_recv_channel.sv
// data_recv_channel
//   AXI read-data receive stage of the memcopy engine. It consumes R-channel
//   beats for bursts issued by the address stage, checks every beat against
//   the expected burst length and against RRESP, and forwards good payload
//   through a 1-deep output register.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   engine_start        1-cycle pulse starting a transfer (honoured in IDLE/ERROR)
//   total_beat_count    beats in the transfer, sampled on engine_start
//   len_push, len_in    expected burst length (AXI LEN) from each AR handshake
//   len_fifo_full       length FIFO full; address stage must hold ARVALID low
//   axi_r*              AXI R channel (rdata, rresp, rlast, rvalid in; rready out)
//   data_out*           registered payload with valid/ready handshake
//   data_error          sticky fault flag
//   error_code          01 RRESP not OKAY, 10 RLAST misplaced, 11 beat with no length
//   data_recv_done      1-cycle pulse once every beat has been delivered
//   dbg_state           current FSM state (0 IDLE, 1 RECV, 2 DONE, 3 ERROR)
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; valid, once raised, is held with stable data until
// that edge; ready may change freely.
module data_recv_channel #(
    parameter int DATA_WIDTH     = 512,
    parameter int LEN_FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  engine_start,
    input  logic [39:0]           total_beat_count,
    input  logic                  len_push,
    input  logic [7:0]            len_in,
    output logic                  len_fifo_full,
    input  logic [DATA_WIDTH-1:0] axi_rdata,
    input  logic [1:0]            axi_rresp,
    input  logic                  axi_rlast,
    input  logic                  axi_rvalid,
    output logic                  axi_rready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic                  data_error,
    output logic [1:0]            error_code,
    output logic                  data_recv_done,
    output logic [1:0]            dbg_state
);

    localparam int PW = $clog2(LEN_FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_DONE  = 2'd2,
        S_ERROR = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [39:0]           total_q, total_d;
    logic [39:0]           rx_q, rx_d;
    logic [8:0]            beat_q, beat_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;
    logic                  done_q, done_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [PW-1:0]         wr_q, wr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [7:0]            len_mem [LEN_FIFO_DEPTH];

    logic       rready;
    logic       start_ok;
    logic       fifo_empty;
    logic       fifo_full;
    logic [7:0] head;
    logic       accept;
    logic [1:0] fault_code;
    logic       fault;
    logic       pop;
    logic       push_ok;

    assign start_ok   = engine_start && (state_q == S_IDLE || state_q == S_ERROR);
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CW'(LEN_FIFO_DEPTH));
    assign head       = len_mem[rd_q];
    assign accept     = (state_q == S_RECV) && axi_rvalid && rready;

    // Beat checks, highest priority first: no expected length, bad
    // response, RLAST not exactly on the final beat of the burst.
    always_comb begin
        fault_code = 2'b00;
        if (fifo_empty) begin
            fault_code = 2'b11;
        end else if (axi_rresp != 2'b00) begin
            fault_code = 2'b01;
        end else if (axi_rlast != (beat_q == {1'b0, head})) begin
            fault_code = 2'b10;
        end
    end

    assign fault   = accept && (fault_code != 2'b00);
    assign pop     = accept && !fault && axi_rlast;
    // A full FIFO can still take a push when the head is popped this cycle.
    assign push_ok = len_push && (state_q != S_IDLE) && !start_ok && (!fifo_full || pop);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (engine_start) begin
                    state_d = (total_beat_count != 40'd0) ? S_RECV : S_DONE;
                end
            end
            S_RECV: begin
                if (fault) begin
                    state_d = S_ERROR;
                end else if (rx_q == total_q && (!valid_q || data_out_ready)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. In RECV no beat is taken once the whole transfer has
    // arrived; in ERROR everything is drained and dropped.
    always_comb begin
        rready = 1'b0;
        done_d = 1'b0;
        case (state_q)
            S_RECV:  rready = (rx_q != total_q) && (!valid_q || data_out_ready);
            S_ERROR: rready = 1'b1;
            S_DONE:  done_d = 1'b1;
            default: rready = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        total_d = total_q;
        rx_d    = rx_q;
        beat_d  = beat_q;
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        code_d  = code_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;

        if (start_ok) begin
            total_d = total_beat_count;
            rx_d    = '0;
            beat_d  = '0;
            err_d   = 1'b0;
            code_d  = 2'b00;
            rd_d    = '0;
            wr_d    = '0;
            cnt_d   = '0;
        end else begin
            if (accept) begin
                rx_d = rx_q + 40'd1;
                if (fault) begin
                    if (!err_q) begin
                        err_d  = 1'b1;
                        code_d = fault_code;
                    end
                end else begin
                    beat_d = axi_rlast ? 9'd0 : beat_q + 9'd1;
                end
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            if (push_ok) begin
                wr_d = wr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        // A new good beat refills the register even while it is draining.
        if (accept && !fault) begin
            data_d  = axi_rdata;
            valid_d = 1'b1;
        end else if (data_out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            total_q <= '0;
            rx_q    <= '0;
            beat_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= 2'b00;
            done_q  <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            total_q <= total_d;
            rx_q    <= rx_d;
            beat_q  <= beat_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            code_q  <= code_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Length storage needs no reset: entries are only read when counted.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            len_mem[wr_q] <= len_in;
        end
    end

    assign len_fifo_full  = fifo_full;
    assign axi_rready     = rready;
    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign data_error     = err_q;
    assign error_code     = code_q;
    assign data_recv_done = done_q;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_data_recv_channel.sv
// Testbench for data_recv_channel: directed scenarios plus randomized
// transfers, compared against a burst-level reference model.
module tb_data_recv_channel;

    localparam int DW    = 64;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          engine_start = 1'b0;
    logic [39:0]   total_beat_count = '0;
    logic          len_push = 1'b0;
    logic [7:0]    len_in = '0;
    logic          len_fifo_full;
    logic [DW-1:0] axi_rdata = '0;
    logic [1:0]    axi_rresp = '0;
    logic          axi_rlast = 1'b0;
    logic          axi_rvalid = 1'b0;
    logic          axi_rready;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready = 1'b0;
    logic          data_error;
    logic [1:0]    error_code;
    logic          data_recv_done;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    data_recv_channel #(.DATA_WIDTH(DW), .LEN_FIFO_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .engine_start     (engine_start),
        .total_beat_count (total_beat_count),
        .len_push         (len_push),
        .len_in           (len_in),
        .len_fifo_full    (len_fifo_full),
        .axi_rdata        (axi_rdata),
        .axi_rresp        (axi_rresp),
        .axi_rlast        (axi_rlast),
        .axi_rvalid       (axi_rvalid),
        .axi_rready       (axi_rready),
        .data_out         (data_out),
        .data_out_valid   (data_out_valid),
        .data_out_ready   (data_out_ready),
        .data_error       (data_error),
        .error_code       (error_code),
        .data_recv_done   (data_recv_done),
        .dbg_state        (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [7:0]    lens_q[$];      // lengths the DUT should hold
    logic [7:0]    plan_lens[$];   // lengths the address stage would push
    logic [DW-1:0] bd[$];
    logic [1:0]    br[$];
    logic          bl[$];
    int            exp_code = 0;
    int            ready_mode = 0; // 0 always, 1 toggle, 2 random
    bit            chk_hold = 1'b0;
    int            done_cnt = 0;
    logic [DW-1:0] mon_tmp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ---------------- downstream ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       data_out_ready = 1'b1;
                1:       data_out_ready = ~data_out_ready;
                default: data_out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (data_out_valid && data_out_ready) begin
                check("out_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_tmp = exp_q.pop_front();
                    check("out_data", data_out, mon_tmp);
                end
            end
            if (chk_hold && data_out_valid && !data_out_ready)
                check("rready_hold", axi_rready, 0);
            if (data_recv_done) begin
                done_cnt++;
                check("done_no_err", data_error, 0);
                check("done_after_out", exp_q.size(), 0);
            end
        end
    end

    // ---------------- plan building / reference model ----------------
    task automatic plan_clear();
        plan_lens.delete();
        bd.delete();
        br.delete();
        bl.delete();
    endtask

    task automatic plan_burst(input logic [7:0] l);
        plan_lens.push_back(l);
        for (int i = 0; i <= int'(l); i++) begin
            bd.push_back({$urandom, $urandom});
            br.push_back(2'b00);
            bl.push_back(i == int'(l));
        end
    endtask

    // Walk the beats in order against the queued lengths: good beats are
    // expected downstream; the first faulting beat decides the code.
    task automatic run_model();
        logic [7:0] lq[$];
        int bib;
        lq = lens_q;
        bib = 0;
        exp_code = 0;
        for (int i = 0; i < bd.size(); i++) begin
            if (lq.size() == 0) begin exp_code = 3; break; end
            if (br[i] != 2'b00) begin exp_code = 1; break; end
            if (bl[i] != (bib == int'(lq[0]))) begin exp_code = 2; break; end
            exp_q.push_back(bd[i]);
            if (bl[i]) begin
                void'(lq.pop_front());
                bib = 0;
            end else begin
                bib++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_xfer(input logic [39:0] total);
        lens_q.delete();
        exp_q.delete();
        done_cnt = 0;
        engine_start = 1'b1;
        total_beat_count = total;
        tick();
        engine_start = 1'b0;
        check("start_clr_err", data_error, 0);
        check("start_clr_code", error_code, 0);
    endtask

    task automatic push_len(input logic [7:0] l);
        len_push = 1'b1;
        len_in = l;
        if (lens_q.size() < DEPTH) lens_q.push_back(l);
        tick();
        len_push = 1'b0;
        check("fifo_full", len_fifo_full, lens_q.size() == DEPTH);
    endtask

    task automatic drive_beats(input int max_gap, input int n);
        bit hs;
        int budget;
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) tick($urandom_range(0, max_gap));
            axi_rvalid = 1'b1;
            axi_rdata  = bd[i];
            axi_rresp  = br[i];
            axi_rlast  = bl[i];
            hs = 1'b0;
            budget = 0;
            while (!hs && budget < 200) begin
                @(negedge clk);
                hs = axi_rready;
                @(posedge clk);
                #1;
                budget++;
            end
            check("beat_accept", hs, 1);
            axi_rvalid = 1'b0;
            axi_rlast  = 1'b0;
            axi_rresp  = 2'b00;
            if (!hs) break;
        end
    endtask

    task automatic finish_xfer();
        int budget;
        budget = 0;
        if (exp_code == 0) begin
            while (done_cnt == 0 && budget < 300) begin tick(); budget++; end
            tick(3);
        end else begin
            while (exp_q.size() != 0 && budget < 300) begin tick(); budget++; end
            tick(5);
            check("rready_err", axi_rready, 1);
        end
        check("left_outputs", exp_q.size(), 0);
        check("done_cnt", done_cnt, exp_code == 0);
        check("err_flag", data_error, exp_code != 0);
        check("err_code", error_code, exp_code);
    endtask

    task automatic execute(input bit do_push, input int max_gap);
        start_xfer(bd.size());
        if (do_push)
            for (int i = 0; i < plan_lens.size(); i++) push_len(plan_lens[i]);
        run_model();
        drive_beats(max_gap, bd.size());
        finish_xfer();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        tick(3);
        check("rst_valid", data_out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_err", data_error, 0);
        check("rst_code", error_code, 0);
        check("rst_done", data_recv_done, 0);
        check("rst_full", len_fifo_full, 0);
        check("rst_rready", axi_rready, 0);
        rst = 1'b0;
        tick(2);

        // T1: two 4-beat bursts, downstream always ready
        ready_mode = 0; chk_hold = 1'b1;
        plan_clear(); plan_burst(8'd3); plan_burst(8'd3);
        execute(1'b1, 0);

        // T2: one 4-beat burst, downstream ready toggling
        ready_mode = 1; chk_hold = 1'b1;
        plan_clear(); plan_burst(8'd3);
        execute(1'b1, 1);

        // T3: bad RRESP on the third beat
        ready_mode = 2; chk_hold = 1'b0;
        plan_clear(); plan_burst(8'd3); plan_burst(8'd3);
        br[2] = 2'b10;
        execute(1'b1, 1);

        // T4: RLAST early on the third beat, then a clean transfer
        plan_clear(); plan_burst(8'd3);
        bl[2] = 1'b1;
        execute(1'b1, 0);
        chk_hold = 1'b1;
        plan_clear(); plan_burst(8'd3);
        execute(1'b1, 1);

        // T5a: beats with no expected length
        chk_hold = 1'b0;
        plan_clear(); plan_burst(8'd3);
        execute(1'b0, 0);

        // T5b: nine pushes, the ninth lands on a full FIFO and is dropped
        ready_mode = 0;
        plan_clear();
        for (int i = 0; i < 9; i++) plan_burst(8'd3);
        execute(1'b1, 0);

        // Randomized transfers
        for (int it = 0; it < 8; it++) begin
            int nb;
            ready_mode = $urandom_range(0, 2);
            plan_clear();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) plan_burst(8'($urandom_range(0, 5)));
            chk_hold = 1'b1;
            if ($urandom_range(0, 2) == 0) begin
                int idx;
                idx = $urandom_range(0, bd.size() - 1);
                if ($urandom_range(0, 1) == 0) br[idx] = 2'($urandom_range(1, 3));
                else bl[idx] = ~bl[idx];
                chk_hold = 1'b0;
            end
            execute(1'b1, 2);
        end

        // T6a: zero-length transfer, done exactly two cycles after start
        chk_hold = 1'b0;
        ready_mode = 0;
        lens_q.delete(); exp_q.delete(); done_cnt = 0;
        engine_start = 1'b1;
        total_beat_count = 40'd0;
        tick();
        engine_start = 1'b0;
        @(negedge clk); check("zero_done_c1", data_recv_done, 0);
        @(negedge clk); check("zero_done_c2", data_recv_done, 1);
        @(negedge clk); check("zero_done_c3", data_recv_done, 0);
        tick(2);
        check("zero_done_cnt", done_cnt, 1);

        // T6b: reset in the middle of a burst
        plan_clear(); plan_burst(8'd3); plan_burst(8'd3);
        start_xfer(bd.size());
        for (int i = 0; i < plan_lens.size(); i++) push_len(plan_lens[i]);
        run_model();
        drive_beats(0, 3);
        check("pre_rst_valid", data_out_valid, 1);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("mid_rst_valid", data_out_valid, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_rready", axi_rready, 0);
        check("mid_rst_full", len_fifo_full, 0);
        check("mid_rst_err", data_error, 0);
        check("mid_rst_done", data_recv_done, 0);
        tick(2);
        rst = 1'b0;
        tick(6);
        check("rst_no_done", done_cnt, 0);

        // Recovery after reset
        chk_hold = 1'b1;
        ready_mode = 2;
        plan_clear(); plan_burst(8'd1); plan_burst(8'd4);
        execute(1'b1, 1);

        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
